ex_queue: RTL and testbench
===========================

Name: ex_queue

Overview:
- Parameterised in-order FIFO between the execute units and writeback (X→W) stage.
- Buffers execute-result messages: pc, seq_num, waddr, wdata, wen.
- Uses val/rdy handshakes on both sides, decoupling execute-unit completion from writeback acceptance.
- Messages leave in exactly the order they entered, bit-for-bit unchanged.

Parameters:
- p_seq_num_bits, 5, width of the sequence-number field (must be ≥1).
- p_depth, 8, number of message entries (must be ≥1; need not be a power of two).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_pc  input  32  incoming instruction PC.
- in_seq_num  input  p_seq_num_bits  incoming sequence number.
- in_waddr  input  5  incoming destination register address.
- in_wdata  input  32  incoming write data.
- in_wen  input  1  incoming register write enable.
- in_val  input  1  producer has a valid message.
- in_rdy  output  1  queue can accept a message.
- out_pc  output  32  head-entry PC.
- out_seq_num  output  p_seq_num_bits  head-entry sequence number.
- out_waddr  output  5  head-entry waddr.
- out_wdata  output  32  head-entry wdata.
- out_wen  output  1  head-entry wen.
- out_val  output  1  head entry is valid.
- out_rdy  input  1  consumer accepts the head entry.

Behaviour:
- Storage: p_depth entries, each 70 + p_seq_num_bits bits. Also a write pointer, a read pointer and an occupancy count.
  - Count width is clog2(p_depth+1).
  - Pointers wrap explicitly from p_depth-1 to 0, so non-power-of-two depths work.
- Reset (rst=1, asynchronous): pointers and count go to 0 immediately. Consequently in_rdy=1 and out_val=0 while rst is high and after it deasserts. Entry contents are not reset.
- Reset mid-operation: all queued messages are discarded. The queue is empty on the first edge after rst deasserts.
- in_rdy = (count != p_depth). It depends only on state, with no combinational path from out_rdy.
- out_val = (count != 0). The out_* data fields are combinationally the entry at the read pointer. They are don't-care when out_val=0.
- Enqueue: occurs when in_val && in_rdy at a rising edge.
  - The message is written at the write pointer, which then advances.
  - in_val may be asserted without in_rdy; the producer holds the message until accepted.
- Dequeue: occurs when out_val && out_rdy at a rising edge; the read pointer advances.
- Count update: +1 on enqueue only, −1 on dequeue only, unchanged on both or neither.
- Latency: a message enqueued at edge N is visible on out_* with out_val=1 immediately after edge N. There is no same-cycle bypass from in to out.
- Full: simultaneous enqueue and dequeue is permitted only when not full (in_rdy=0 when full). With p_depth=1 this gives at most one message per two cycles.
- Empty: out_val=0. A dequeue request (out_rdy=1) has no effect and the count never underflows.
- Simultaneous enqueue and dequeue when 0 < count < p_depth: both happen, count unchanged, order preserved.
- Data fields pass through unmodified; no field (including wen) is interpreted.

Test Plan:
1. Basic: after reset, send {pc=0,seq=0,waddr=0,wdata=0,wen=0} with the consumer always ready → exactly that message received, out_val high on the cycle after acceptance.
2. Backpressure: send pc=0..5 (other fields 0) back-to-back; consumer holds out_rdy=0 for 3 cycles, then ready → pc 0,1,2,3,4,5 received in order. With p_depth=1/2/4, in_rdy drops at full and nothing is lost or duplicated.
3. Random stream: 30 random messages (random pc, seq_num of p_seq_num_bits, waddr, wdata, wen) under all parameter sets:
   - (5,8); (6,4); (3,1); (4,2) with 3-cycle send gaps; (9,32) with 3-cycle receive gaps; (5,8) with both gaps.
   - Required response: all 30 messages received in order, bit-exact.
4. Full/wrap: with p_depth=4, enqueue 4 → in_rdy=0. Dequeue 1 → in_rdy=1. Keep streaming 10 more → pointers wrap and order is preserved.
5. Simultaneous: at count=2 of 8, assert in_val and out_rdy for 5 cycles → count stays 2, outputs come out in FIFO order.
6. Async reset mid-stream: with 3 entries queued, pulse rst between clock edges → out_val falls and in_rdy rises without waiting for a clock edge. Later traffic is unaffected by the discarded entries.

Source files
------------

// File: rtl/ex_queue.sv
// In-order X->W result queue with val/rdy on both sides; an entry accepted at edge N is visible on out_* just after N.
// Backpressure: in_rdy drops only when full and is a function of state alone; out_rdy never reaches in_rdy.
module ex_queue #(
    parameter int p_seq_num_bits = 5,
    parameter int p_depth        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               in_pc,
    input  logic [p_seq_num_bits-1:0] in_seq_num,
    input  logic [4:0]                in_waddr,
    input  logic [31:0]               in_wdata,
    input  logic                      in_wen,
    input  logic                      in_val,
    output logic                      in_rdy,
    output logic [31:0]               out_pc,
    output logic [p_seq_num_bits-1:0] out_seq_num,
    output logic [4:0]                out_waddr,
    output logic [31:0]               out_wdata,
    output logic                      out_wen,
    output logic                      out_val,
    input  logic                      out_rdy
);
    localparam int ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int cnt_w = $clog2(p_depth + 1);

    typedef struct packed {
        logic [31:0]               pc;
        logic [p_seq_num_bits-1:0] seq_num;
        logic [4:0]                waddr;
        logic [31:0]               wdata;
        logic                      wen;
    } entry_t;

    entry_t           mem [p_depth];
    entry_t           head;
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             enq;
    logic             deq;

    // Explicit wrap so that non-power-of-two depths cycle correctly.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(p_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_rdy  = (count != cnt_w'(p_depth));
    assign out_val = (count != '0);
    assign enq     = in_val && in_rdy;
    assign deq     = out_val && out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= next_ptr(wr_ptr);
            if (deq) rd_ptr <= next_ptr(rd_ptr);
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; stale contents are masked by out_val.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{pc: in_pc, seq_num: in_seq_num, waddr: in_waddr,
                             wdata: in_wdata, wen: in_wen};
        end
    end

    assign head        = mem[rd_ptr];
    assign out_pc      = head.pc;
    assign out_seq_num = head.seq_num;
    assign out_waddr   = head.waddr;
    assign out_wdata   = head.wdata;
    assign out_wen     = head.wen;
endmodule

// File: tb/tb_ex_queue.sv
// Directed bench for ex_queue: three instances (depth 8, 4 and 1) exercised scenario by scenario.
module tb_ex_queue;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [8:0]  seq;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
    } msg_t;

    // Instance a: (5,8)
    logic [31:0] a_in_pc, a_out_pc, a_in_wdata, a_out_wdata;
    logic [4:0]  a_in_seq, a_out_seq, a_in_waddr, a_out_waddr;
    logic        a_in_wen, a_out_wen, a_in_val, a_in_rdy, a_out_val, a_out_rdy;
    // Instance b: (6,4)
    logic [31:0] b_in_pc, b_out_pc, b_in_wdata, b_out_wdata;
    logic [5:0]  b_in_seq, b_out_seq;
    logic [4:0]  b_in_waddr, b_out_waddr;
    logic        b_in_wen, b_out_wen, b_in_val, b_in_rdy, b_out_val, b_out_rdy;
    // Instance c: (3,1)
    logic [31:0] c_in_pc, c_out_pc, c_in_wdata, c_out_wdata;
    logic [2:0]  c_in_seq, c_out_seq;
    logic [4:0]  c_in_waddr, c_out_waddr;
    logic        c_in_wen, c_out_wen, c_in_val, c_in_rdy, c_out_val, c_out_rdy;

    ex_queue #(.p_seq_num_bits(5), .p_depth(8)) u_a (
        .clk(clk), .rst(rst), .in_pc(a_in_pc), .in_seq_num(a_in_seq), .in_waddr(a_in_waddr),
        .in_wdata(a_in_wdata), .in_wen(a_in_wen), .in_val(a_in_val), .in_rdy(a_in_rdy),
        .out_pc(a_out_pc), .out_seq_num(a_out_seq), .out_waddr(a_out_waddr),
        .out_wdata(a_out_wdata), .out_wen(a_out_wen), .out_val(a_out_val), .out_rdy(a_out_rdy));

    ex_queue #(.p_seq_num_bits(6), .p_depth(4)) u_b (
        .clk(clk), .rst(rst), .in_pc(b_in_pc), .in_seq_num(b_in_seq), .in_waddr(b_in_waddr),
        .in_wdata(b_in_wdata), .in_wen(b_in_wen), .in_val(b_in_val), .in_rdy(b_in_rdy),
        .out_pc(b_out_pc), .out_seq_num(b_out_seq), .out_waddr(b_out_waddr),
        .out_wdata(b_out_wdata), .out_wen(b_out_wen), .out_val(b_out_val), .out_rdy(b_out_rdy));

    ex_queue #(.p_seq_num_bits(3), .p_depth(1)) u_c (
        .clk(clk), .rst(rst), .in_pc(c_in_pc), .in_seq_num(c_in_seq), .in_waddr(c_in_waddr),
        .in_wdata(c_in_wdata), .in_wen(c_in_wen), .in_val(c_in_val), .in_rdy(c_in_rdy),
        .out_pc(c_out_pc), .out_seq_num(c_out_seq), .out_waddr(c_out_waddr),
        .out_wdata(c_out_wdata), .out_wen(c_out_wen), .out_val(c_out_val), .out_rdy(c_out_rdy));

    // salt 0 gives {pc=i, everything else 0}; other salts give a hashed message.
    function automatic msg_t mk(input int i, input int salt, input int bits);
        msg_t        m;
        logic [31:0] h;
        logic [8:0]  mask;
        m    = '0;
        mask = 9'((1 << bits) - 1);
        if (salt == 0) begin
            m.pc = 32'(i);
        end else begin
            h       = 32'(i) * 32'h9E37_79B9 + 32'(salt) * 32'h0101_0101;
            m.pc    = h ^ 32'h0040_0000;
            m.seq   = h[20:12] & mask;
            m.waddr = h[27:23];
            m.wdata = {h[15:0], h[31:16]} ^ 32'(salt);
            m.wen   = h[5];
        end
        return m;
    endfunction

    task automatic drive_a(input msg_t m);
        a_in_pc = m.pc; a_in_seq = m.seq[4:0]; a_in_waddr = m.waddr;
        a_in_wdata = m.wdata; a_in_wen = m.wen;
    endtask
    task automatic drive_b(input msg_t m);
        b_in_pc = m.pc; b_in_seq = m.seq[5:0]; b_in_waddr = m.waddr;
        b_in_wdata = m.wdata; b_in_wen = m.wen;
    endtask
    task automatic drive_c(input msg_t m);
        c_in_pc = m.pc; c_in_seq = m.seq[2:0]; c_in_waddr = m.waddr;
        c_in_wdata = m.wdata; c_in_wen = m.wen;
    endtask

    function automatic msg_t get_a();
        msg_t m;
        m = '0; m.pc = a_out_pc; m.seq = 9'(a_out_seq); m.waddr = a_out_waddr;
        m.wdata = a_out_wdata; m.wen = a_out_wen;
        return m;
    endfunction
    function automatic msg_t get_b();
        msg_t m;
        m = '0; m.pc = b_out_pc; m.seq = 9'(b_out_seq); m.waddr = b_out_waddr;
        m.wdata = b_out_wdata; m.wen = b_out_wen;
        return m;
    endfunction
    function automatic msg_t get_c();
        msg_t m;
        m = '0; m.pc = c_out_pc; m.seq = 9'(c_out_seq); m.waddr = c_out_waddr;
        m.wdata = c_out_wdata; m.wen = c_out_wen;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (a_in_rdy !== 1'b1 || a_out_val !== 1'b0) begin
            failures++;
            $display("FAIL reset_a in_rdy=%b out_val=%b want 1/0", a_in_rdy, a_out_val);
        end
        checks++;
        if (b_in_rdy !== 1'b1 || b_out_val !== 1'b0 || c_in_rdy !== 1'b1 || c_out_val !== 1'b0) begin
            failures++;
            $display("FAIL reset_bc b=%b/%b c=%b/%b want 1/0", b_in_rdy, b_out_val, c_in_rdy, c_out_val);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (a_in_rdy !== 1'b1 || a_out_val !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_a in_rdy=%b out_val=%b want 1/0", a_in_rdy, a_out_val);
        end
    endtask

    task automatic test_basic();
        msg_t exp;
        exp = mk(0, 0, 5);
        drive_a(exp);
        a_in_val  = 1'b1;
        a_out_rdy = 1'b1;
        #1;
        checks++;
        if (a_out_val !== 1'b0 || a_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL basic_pre out_val=%b in_rdy=%b want 0/1", a_out_val, a_in_rdy);
        end
        tick();
        a_in_val = 1'b0;
        checks++;
        if (a_out_val !== 1'b1 || get_a() !== exp) begin
            failures++;
            $display("FAIL basic_latency out_val=%b got=%h want 1/%h", a_out_val, get_a(), exp);
        end
        tick();
        a_out_rdy = 1'b0;
        checks++;
        if (a_out_val !== 1'b0) begin
            failures++;
            $display("FAIL basic_single out_val=%b want 0", a_out_val);
        end
    endtask

    // Producer and consumer on instance a with optional gaps and an initial consumer stall.
    task automatic stream_a(input int n, input int salt, input int send_gap, input int recv_gap,
                            input int hold, input string name);
        int   sent = 0;
        int   rcvd = 0;
        int   sg   = 0;
        int   rg   = hold;
        int   cyc  = 0;
        logic enq, deq;
        msg_t exp;
        while (rcvd < n && cyc < 2000) begin
            a_in_val = (sent < n) && (sg == 0);
            drive_a(mk(sent, salt, 5));
            a_out_rdy = (rg == 0);
            #1;
            enq = a_in_val && a_in_rdy;
            deq = a_out_val && a_out_rdy;
            if (deq) begin
                exp = mk(rcvd, salt, 5);
                checks++;
                if (get_a() !== exp) begin
                    failures++;
                    $display("FAIL %s msg%0d got=%h want %h", name, rcvd, get_a(), exp);
                end
                rcvd++;
                rg = recv_gap;
            end else if (rg > 0) begin
                rg--;
            end
            if (enq) begin
                sent++;
                sg = send_gap;
            end else if (sg > 0) begin
                sg--;
            end
            tick();
            cyc++;
        end
        a_in_val  = 1'b0;
        a_out_rdy = 1'b0;
        checks++;
        if (rcvd != n) begin
            failures++;
            $display("FAIL %s_count received=%0d want %0d", name, rcvd, n);
        end
        #1;
        checks++;
        if (a_out_val !== 1'b0) begin
            failures++;
            $display("FAIL %s_leftover out_val=%b want 0", name, a_out_val);
        end
    endtask

    task automatic test_simultaneous();
        a_out_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_a(mk(i, 7, 5));
            a_in_val = 1'b1;
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive_a(mk(k + 2, 7, 5));
            a_in_val  = 1'b1;
            a_out_rdy = 1'b1;
            #1;
            checks++;
            if (a_in_rdy !== 1'b1 || a_out_val !== 1'b1 || get_a() !== mk(k, 7, 5)) begin
                failures++;
                $display("FAIL simul_%0d rdy=%b val=%b got=%h want 1/1/%h", k, a_in_rdy, a_out_val,
                         get_a(), mk(k, 7, 5));
            end
            tick();
        end
        a_in_val = 1'b0;
        for (int k = 5; k < 7; k++) begin
            checks++;
            if (a_out_val !== 1'b1 || get_a() !== mk(k, 7, 5)) begin
                failures++;
                $display("FAIL simul_drain_%0d val=%b got=%h want 1/%h", k, a_out_val, get_a(), mk(k, 7, 5));
            end
            tick();
        end
        a_out_rdy = 1'b0;
        checks++;
        if (a_out_val !== 1'b0) begin
            failures++;
            $display("FAIL simul_count out_val=%b want 0 after draining two", a_out_val);
        end
    endtask

    task automatic test_async_reset();
        a_out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_a(mk(i, 9, 5));
            a_in_val = 1'b1;
            tick();
        end
        a_in_val = 1'b0;
        checks++;
        if (a_out_val !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre out_val=%b want 1", a_out_val);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (a_out_val !== 1'b0 || a_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL arst_async out_val=%b in_rdy=%b want 0/1", a_out_val, a_in_rdy);
        end
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (a_out_val !== 1'b0) begin
            failures++;
            $display("FAIL arst_empty out_val=%b want 0", a_out_val);
        end
        stream_a(8, 11, 0, 0, 0, "post_rst");
    endtask

    task automatic test_full_wrap();
        int   sent = 4;
        int   rcvd = 1;
        int   cyc  = 0;
        logic enq, deq;
        b_out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_b(mk(i, 5, 6));
            b_in_val = 1'b1;
            #1;
            checks++;
            if (b_in_rdy !== 1'b1) begin
                failures++;
                $display("FAIL fill_%0d in_rdy=%b want 1", i, b_in_rdy);
            end
            tick();
        end
        drive_b(mk(4, 5, 6));
        tick();
        checks++;
        if (b_in_rdy !== 1'b0 || b_out_val !== 1'b1) begin
            failures++;
            $display("FAIL full in_rdy=%b out_val=%b want 0/1", b_in_rdy, b_out_val);
        end
        b_out_rdy = 1'b1;
        #1;
        checks++;
        if (get_b() !== mk(0, 5, 6)) begin
            failures++;
            $display("FAIL full_head got=%h want %h", get_b(), mk(0, 5, 6));
        end
        tick();
        checks++;
        if (b_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL after_deq in_rdy=%b want 1", b_in_rdy);
        end
        while (rcvd < 14 && cyc < 200) begin
            b_in_val = (sent < 14);
            drive_b(mk(sent, 5, 6));
            b_out_rdy = 1'b1;
            #1;
            enq = b_in_val && b_in_rdy;
            deq = b_out_val && b_out_rdy;
            if (deq) begin
                checks++;
                if (get_b() !== mk(rcvd, 5, 6)) begin
                    failures++;
                    $display("FAIL wrap msg%0d got=%h want %h", rcvd, get_b(), mk(rcvd, 5, 6));
                end
                rcvd++;
            end
            if (enq) sent++;
            tick();
            cyc++;
        end
        b_in_val  = 1'b0;
        b_out_rdy = 1'b0;
        #1;
        checks++;
        if (rcvd != 14 || b_out_val !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end received=%0d out_val=%b want 14/0", rcvd, b_out_val);
        end
    endtask

    task automatic test_depth1();
        int sent = 0;
        int rcvd = 0;
        for (int k = 0; k < 6; k++) begin
            drive_c(mk(sent, 3, 3));
            c_in_val  = 1'b1;
            c_out_rdy = 1'b1;
            #1;
            if (c_out_val && c_out_rdy) begin
                checks++;
                if (get_c() !== mk(rcvd, 3, 3)) begin
                    failures++;
                    $display("FAIL depth1 msg%0d got=%h want %h", rcvd, get_c(), mk(rcvd, 3, 3));
                end
                rcvd++;
            end
            if (c_in_val && c_in_rdy) sent++;
            tick();
        end
        c_in_val  = 1'b0;
        c_out_rdy = 1'b0;
        checks++;
        if (sent != 3 || rcvd != 3) begin
            failures++;
            $display("FAIL depth1_rate sent=%0d received=%0d want 3/3", sent, rcvd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        a_in_val = 1'b0; a_out_rdy = 1'b0; drive_a('0);
        b_in_val = 1'b0; b_out_rdy = 1'b0; drive_b('0);
        c_in_val = 1'b0; c_out_rdy = 1'b0; drive_c('0);
        test_reset();
        test_basic();
        stream_a(6, 0, 0, 0, 3, "backpressure");
        stream_a(30, 21, 0, 0, 0, "stream");
        stream_a(30, 33, 3, 0, 0, "send_gap");
        stream_a(30, 45, 0, 3, 0, "recv_gap");
        stream_a(30, 57, 3, 3, 0, "both_gap");
        test_full_wrap();
        test_simultaneous();
        test_depth1();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
